id_fwd_scoreboard: RTL and testbench

- Parametrised ID-stage operand forwarding and hazard unit for the 5-stage MIPS pipeline.
- Keeps a registered shadow of destination tags for EX/MEM/WB, one entry per stage.
- Drives the forwarded source operands for NUM_SRC register reads and a pipeline stall.
- Stalls on load-use hazards and on multi-cycle multiply occupancy. Replaces the fixed rs/rt forwarding muxes.

---
 rtl/id_fwd_pkg.sv | 14 +
 rtl/id_fwd_scoreboard_fwd_src_sel.sv | 44 ++++
 rtl/id_fwd_scoreboard.sv | 75 +++++++
 tb/tb_id_fwd_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_fwd_pkg.sv
// id_fwd_pkg: result kinds, forward-select codes and shadow field widths for the ID forwarding unit
package id_fwd_pkg;
  localparam int KIND_W = 2;
  localparam int SEL_W = 3;
  localparam logic [KIND_W-1:0] RES_ALU = 2'd0;
  localparam logic [KIND_W-1:0] RES_LINK = 2'd1;
  localparam logic [KIND_W-1:0] RES_LOAD = 2'd2;
  localparam logic [KIND_W-1:0] RES_MULT = 2'd3;
  localparam logic [SEL_W-1:0] FSEL_RF = 3'd0;
  localparam logic [SEL_W-1:0] FSEL_EX_LINK = 3'd1;
  localparam logic [SEL_W-1:0] FSEL_MEM_RES = 3'd2;
  localparam logic [SEL_W-1:0] FSEL_MEM_LINK = 3'd3;
  localparam logic [SEL_W-1:0] FSEL_WB = 3'd4;
endpackage

// File: rtl/id_fwd_scoreboard_fwd_src_sel.sv
// fwd_src_sel: youngest-match priority compare and operand mux for one ID source
module fwd_src_sel
  import id_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic              used,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_v,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic [KIND_W-1:0] ex_kind,
  input  logic              mem_v,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic [KIND_W-1:0] mem_kind,
  input  logic              wb_v,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] ex_link,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] mem_link,
  input  logic [DATA_W-1:0] wb_result,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);
  logic chk, ex_hit, mem_hit, wb_hit;
  always_comb begin
    chk = en && used && addr != '0;
    ex_hit = chk && ex_v && ex_dst == addr;
    mem_hit = chk && mem_v && mem_dst == addr;
    wb_hit = chk && wb_v && wb_dst == addr;
    // a hazarding operand falls back to rf data so the output never goes X
    sel = ex_hit ? (ex_kind == RES_LINK ? FSEL_EX_LINK : FSEL_RF) :
          mem_hit ? (mem_kind == RES_LOAD ? FSEL_RF : mem_kind == RES_LINK ? FSEL_MEM_LINK : FSEL_MEM_RES) :
          wb_hit ? FSEL_WB : FSEL_RF;
    hazard = ex_hit ? ex_kind != RES_LINK : mem_hit && mem_kind == RES_LOAD;
    data = sel == FSEL_EX_LINK ? ex_link :
           sel == FSEL_MEM_RES ? mem_result :
           sel == FSEL_MEM_LINK ? mem_link :
           sel == FSEL_WB ? wb_result : rf_data;
  end
endmodule

// File: rtl/id_fwd_scoreboard.sv
// id_fwd_scoreboard: EX/MEM/WB destination shadow, operand forwarding and load-use/multiply stall
module id_fwd_scoreboard
  import id_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int MULT_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0] id_rf_data,
  input  logic                      id_wr_en,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic [KIND_W-1:0]         id_res_kind,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         ex_link,
  input  logic [DATA_W-1:0]         mem_result,
  input  logic [DATA_W-1:0]         mem_link,
  input  logic [DATA_W-1:0]         wb_result,
  output logic [NUM_SRC*DATA_W-1:0] fwd_data,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
);
  localparam int CNT_W = $clog2(MULT_LAT + 1);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(MULT_LAT - 1);
  logic ex_v, mem_v, wb_v, load_ex;
  logic [ADDR_W-1:0] ex_dst, mem_dst, wb_dst;
  logic [KIND_W-1:0] ex_kind, mem_kind;
  logic [CNT_W-1:0] mult_cnt;
  logic [NUM_SRC-1:0] haz;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel (
        .en(!rst), .used(id_src_used[i]), .addr(id_src_addr[i*ADDR_W +: ADDR_W]),
        .rf_data(id_rf_data[i*DATA_W +: DATA_W]),
        .ex_v(ex_v), .ex_dst(ex_dst), .ex_kind(ex_kind),
        .mem_v(mem_v), .mem_dst(mem_dst), .mem_kind(mem_kind),
        .wb_v(wb_v), .wb_dst(wb_dst),
        .ex_link(ex_link), .mem_result(mem_result), .mem_link(mem_link), .wb_result(wb_result),
        .sel(fwd_sel[i*SEL_W +: SEL_W]), .data(fwd_data[i*DATA_W +: DATA_W]), .hazard(haz[i])
      );
    end
  endgenerate
  assign stall = !rst && ((id_valid && |haz) || mult_cnt != '0);
  assign load_ex = id_valid && !stall && !flush;
  // shadow entries store only qualified writers: valid && wr_en && dst != 0
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v <= 1'b0;
      mem_v <= 1'b0;
      wb_v <= 1'b0;
      mult_cnt <= '0;
    end else begin
      wb_v <= mem_v;
      wb_dst <= mem_dst;
      if (mult_cnt != '0) begin
        mem_v <= 1'b0;
        mult_cnt <= mult_cnt - 1'b1;
      end else begin
        mem_v <= ex_v;
        mem_dst <= ex_dst;
        mem_kind <= ex_kind;
        ex_v <= load_ex && id_wr_en && id_dst_addr != '0;
        ex_dst <= id_dst_addr;
        ex_kind <= id_res_kind;
        mult_cnt <= load_ex && id_res_kind == RES_MULT ? HOLD : '0;
      end
    end
  end
endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// tb_id_fwd_scoreboard: directed hazard/forwarding scenarios checked against a pipeline-occupancy model
module tb_id_fwd_scoreboard;
  localparam int DW = 32, AW = 5, NS = 2, ML = 4;
  logic clk = 1'b0, rst, id_valid, flush, id_wr_en, stall;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0] id_src_used;
  logic [NS*DW-1:0] id_rf_data, fwd_data;
  logic [AW-1:0] id_dst_addr;
  logic [1:0] id_res_kind;
  logic [NS*3-1:0] fwd_sel;
  logic [DW-1:0] ex_link = 32'h0040_0008, mem_result = 32'h0000_1234;
  logic [DW-1:0] mem_link = 32'h0040_0010, wb_result = 32'hDEAD_BEEF;
  int vectors = 0, miscompares = 0;
  int mv[3], md[3], mk[3], mcnt;

  always #5 clk = ~clk;

  id_fwd_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .MULT_LAT(ML)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_rf_data(id_rf_data), .id_wr_en(id_wr_en), .id_dst_addr(id_dst_addr), .id_res_kind(id_res_kind),
    .flush(flush), .ex_link(ex_link), .mem_result(mem_result), .mem_link(mem_link), .wb_result(wb_result),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // stages 0/1/2 = EX/MEM/WB; kinds 0 ALU, 1 LINK, 2 LOAD, 3 MULT
  function automatic int exp_sel(input int a, input bit u, output bit hz);
    hz = 0;
    if (!u || a == 0) return 0;
    for (int s = 0; s < 3; s++)
      if (mv[s] != 0 && md[s] == a) begin
        if (s == 2) return 4;
        if (s == 0) begin
          if (mk[0] == 1) return 1;
          hz = 1;
          return 0;
        end
        if (mk[1] == 2) begin
          hz = 1;
          return 0;
        end
        return mk[1] == 1 ? 3 : 2;
      end
    return 0;
  endfunction

  function automatic logic [31:0] sel_data(input int s, input logic [31:0] rf);
    return s == 1 ? ex_link : s == 2 ? mem_result : s == 3 ? mem_link : s == 4 ? wb_result : rf;
  endfunction

  always @(negedge clk) begin
    bit hz[NS];
    int es[NS];
    bit est, ld;
    est = 0;
    for (int i = 0; i < NS; i++) begin
      es[i] = rst ? 0 : exp_sel(int'(id_src_addr[i*AW +: AW]), id_src_used[i], hz[i]);
      if (rst) hz[i] = 0;
      if (hz[i] && id_valid) est = 1;
    end
    if (!rst && mcnt != 0) est = 1;
    chk("model_stall", {31'b0, stall}, {31'b0, est});
    for (int i = 0; i < NS; i++) begin
      if (!hz[i]) begin
        chk($sformatf("model_sel%0d", i), {29'b0, fwd_sel[i*3 +: 3]}, es[i]);
        chk($sformatf("model_data%0d", i), fwd_data[i*DW +: DW], sel_data(es[i], id_rf_data[i*DW +: DW]));
      end else chk($sformatf("data_known%0d", i), {31'b0, $isunknown(fwd_data[i*DW +: DW])}, 0);
    end
    if (rst) begin
      mv = '{0, 0, 0};
      mcnt = 0;
    end else if (mcnt > 0) begin
      mv[2] = mv[1]; md[2] = md[1]; mk[2] = mk[1];
      mv[1] = 0;
      mcnt--;
    end else begin
      mv[2] = mv[1]; md[2] = md[1]; mk[2] = mk[1];
      mv[1] = mv[0]; md[1] = md[0]; mk[1] = mk[0];
      ld = id_valid && !est && !flush;
      mv[0] = int'(ld && id_wr_en && id_dst_addr != 0);
      md[0] = int'(id_dst_addr);
      mk[0] = int'(id_res_kind);
      mcnt = (ld && id_res_kind == 2'd3) ? ML - 1 : 0;
    end
  end

  task automatic set(input bit v, input int a0, input int a1, input bit [1:0] u,
                     input bit wr, input int dst, input int kind, input bit fl = 0);
    id_valid = v;
    id_src_addr = {AW'(a1), AW'(a0)};
    id_src_used = u;
    id_rf_data = {32'hBB00_0000 | 32'(a1), 32'hAA00_0000 | 32'(a0)};
    id_wr_en = wr;
    id_dst_addr = AW'(dst);
    id_res_kind = 2'(kind);
    flush = fl;
  endtask

  task automatic mid;
    @(negedge clk);
    #1;
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc;
    mid();
    adv();
  endtask

  task automatic drain(input int n);
    set(0, 0, 0, 0, 0, 0, 0);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1;
    set(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_sel", {26'b0, fwd_sel}, 0);
    chk("rst_data0", fwd_data[31:0], 32'hAA00_0000);
    adv();
    cyc();
    rst = 0;
    drain(2);
    // ALU -> consumer
    set(1, 0, 0, 0, 1, 8, 0); cyc();
    set(1, 8, 0, 2'b01, 0, 0, 0); mid();
    chk("alu_stall", {31'b0, stall}, 1);
    adv(); mid();
    chk("alu_nostall", {31'b0, stall}, 0);
    chk("alu_sel", {29'b0, fwd_sel[2:0]}, 2);
    chk("alu_data", fwd_data[31:0], 32'h0000_1234);
    adv(); drain(3);
    // load-use
    set(1, 0, 0, 0, 1, 9, 2); cyc();
    set(1, 0, 9, 2'b10, 0, 0, 0); mid();
    chk("lw_stall1", {31'b0, stall}, 1);
    adv(); mid();
    chk("lw_stall2", {31'b0, stall}, 1);
    adv(); mid();
    chk("lw_nostall", {31'b0, stall}, 0);
    chk("lw_sel", {29'b0, fwd_sel[5:3]}, 4);
    chk("lw_data", fwd_data[63:32], 32'hDEAD_BEEF);
    adv(); drain(3);
    // link in EX, then in MEM
    set(1, 0, 0, 0, 1, 31, 1); cyc();
    set(1, 31, 0, 2'b01, 0, 0, 0); mid();
    chk("jal_stall", {31'b0, stall}, 0);
    chk("jal_sel_ex", {29'b0, fwd_sel[2:0]}, 1);
    chk("jal_data_ex", fwd_data[31:0], 32'h0040_0008);
    adv(); drain(3);
    set(1, 0, 0, 0, 1, 31, 1); cyc();
    drain(1);
    set(1, 31, 0, 2'b01, 0, 0, 0); mid();
    chk("jal_sel_mem", {29'b0, fwd_sel[2:0]}, 3);
    chk("jal_data_mem", fwd_data[31:0], 32'h0040_0010);
    adv(); drain(3);
    // multiply hold with an older ALU writer draining through MEM bubbles
    set(1, 0, 0, 0, 1, 11, 0); cyc();
    set(1, 0, 0, 0, 1, 10, 3); cyc();
    set(1, 10, 11, 2'b11, 0, 0, 0); mid();
    chk("mul_stall1", {31'b0, stall}, 1);
    chk("mul_r11_mem", {29'b0, fwd_sel[5:3]}, 2);
    adv(); mid();
    chk("mul_stall2", {31'b0, stall}, 1);
    chk("mul_r11_wb", {29'b0, fwd_sel[5:3]}, 4);
    adv(); mid();
    chk("mul_stall3", {31'b0, stall}, 1);
    chk("mul_r11_gone", {29'b0, fwd_sel[5:3]}, 0);
    adv(); mid();
    chk("mul_stall4", {31'b0, stall}, 1);
    adv(); mid();
    chk("mul_nostall", {31'b0, stall}, 0);
    chk("mul_sel", {29'b0, fwd_sel[2:0]}, 2);
    chk("mul_data", fwd_data[31:0], 32'h0000_1234);
    adv(); drain(3);
    // r0 never forwards; EX beats WB
    repeat (3) begin set(1, 0, 0, 0, 1, 0, 0); cyc(); end
    set(1, 0, 0, 2'b11, 0, 0, 0); mid();
    chk("r0_stall", {31'b0, stall}, 0);
    chk("r0_sel", {26'b0, fwd_sel}, 0);
    adv();
    set(1, 0, 0, 0, 1, 8, 0); cyc();
    set(1, 0, 0, 0, 1, 7, 0); cyc();
    set(1, 0, 0, 0, 1, 8, 1); cyc();
    set(1, 8, 8, 2'b11, 0, 0, 0); mid();
    chk("prio_stall", {31'b0, stall}, 0);
    chk("prio_sel", {26'b0, fwd_sel}, 6'o11);
    adv(); drain(3);
    // reset in the middle of a multiply hold
    set(1, 0, 0, 0, 1, 10, 3); cyc();
    set(1, 10, 0, 2'b01, 0, 0, 0); cyc();
    rst = 1; cyc();
    rst = 0; mid();
    chk("rstmul_stall", {31'b0, stall}, 0);
    chk("rstmul_sel", {29'b0, fwd_sel[2:0]}, 0);
    adv(); drain(3);
    // flush with and without a hazard stall
    set(1, 0, 0, 0, 1, 9, 2); cyc();
    set(1, 9, 0, 2'b01, 1, 12, 0, 1); mid();
    chk("flush_haz_stall", {31'b0, stall}, 1);
    adv();
    set(1, 12, 0, 2'b01, 0, 0, 0); mid();
    chk("flush_haz_after", {31'b0, stall}, 0);
    chk("flush_haz_sel", {29'b0, fwd_sel[2:0]}, 0);
    adv(); drain(3);
    set(1, 0, 0, 0, 1, 12, 0, 1); cyc();
    set(1, 12, 0, 2'b01, 0, 0, 0); mid();
    chk("flush_stall", {31'b0, stall}, 0);
    chk("flush_sel", {29'b0, fwd_sel[2:0]}, 0);
    adv(); drain(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
